// File: rtl/pipelined_block_cla_adder.sv
// Two-stage pipelined block carry-lookahead adder/subtractor with a valid/ready stream.
// Define CLA_OVF_EN to add the registered signed-overflow output (ovf).
module pipelined_block_cla_adder #(
    parameter int N = 64,
    parameter int B = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         P,
    output logic         G
`ifdef CLA_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int NB = N / B;

    generate
        if (N < 2 || (N % B) != 0) begin : g_param_check
            $error("pipelined_block_cla_adder: N must be >= 2 and a multiple of B");
        end
    endgenerate

    // ---------------- handshake ----------------
    logic s1_valid_reg;
    logic s2_ready;
    logic s1_ready;

    assign s2_ready = ~out_valid | out_ready;
    assign s1_ready = ~s1_valid_reg | s2_ready;
    assign in_ready = s1_ready;

    // ---------------- stage 1: bit and block propagate/generate ----------------
    logic [N-1:0]  b_eff;
    logic          c0;
    logic [N-1:0]  p;
    logic [N-1:0]  g;
    logic [NB-1:0] blk_p;
    logic [NB-1:0] blk_g;

    assign b_eff = sub ? ~b : b;
    assign c0    = sub | cin;
    assign p     = a ^ b_eff;
    assign g     = a & b_eff;

    for (genvar gi = 0; gi < NB; gi++) begin : g_block_pg
        logic gen;

        always_comb begin
            gen = 1'b0;
            for (int j = 0; j < B; j++) begin
                gen = g[gi*B+j] | (p[gi*B+j] & gen);
            end
        end

        assign blk_p[gi] = &p[gi*B +: B];
        assign blk_g[gi] = gen;
    end

    logic [N-1:0]  p_reg;
    logic [N-1:0]  g_reg;
    logic          c0_reg;
    logic [NB-1:0] blk_p_reg;
    logic [NB-1:0] blk_g_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            p_reg        <= '0;
            g_reg        <= '0;
            c0_reg       <= 1'b0;
            blk_p_reg    <= '0;
            blk_g_reg    <= '0;
        end else if (s1_ready) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                p_reg     <= p;
                g_reg     <= g;
                c0_reg    <= c0;
                blk_p_reg <= blk_p;
                blk_g_reg <= blk_g;
            end
        end
    end

    // ---------------- stage 2: block lookahead, in-block carries, sum ----------------
    logic [N-1:0] sum_next;
    logic         cout_next;
    logic         word_g_next;

    always_comb begin : stage2_comb
        logic blk_carry;
        logic bit_carry;
        sum_next    = '0;
        word_g_next = 1'b0;
        blk_carry   = c0_reg;
        bit_carry   = 1'b0;
        for (int k = 0; k < NB; k++) begin
            // each block's ripple is seeded by the lookahead carry, not by its neighbour
            bit_carry = blk_carry;
            for (int j = 0; j < B; j++) begin
                sum_next[k*B+j] = p_reg[k*B+j] ^ bit_carry;
                bit_carry       = g_reg[k*B+j] | (p_reg[k*B+j] & bit_carry);
            end
            blk_carry   = blk_g_reg[k] | (blk_p_reg[k] & blk_carry);
            word_g_next = blk_g_reg[k] | (blk_p_reg[k] & word_g_next);
        end
        cout_next = blk_carry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            P         <= 1'b0;
            G         <= 1'b0;
        end else if (s2_ready) begin
            out_valid <= s1_valid_reg;
            if (s1_valid_reg) begin
                sum  <= sum_next;
                cout <= cout_next;
                P    <= &blk_p_reg;
                G    <= word_g_next;
            end
        end
    end

`ifdef CLA_OVF_EN
    logic a_msb_reg;
    logic b_msb_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb_reg <= 1'b0;
            b_msb_reg <= 1'b0;
        end else if (s1_ready && in_valid) begin
            a_msb_reg <= a[N-1];
            b_msb_reg <= b_eff[N-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (s2_ready && s1_valid_reg) begin
            ovf <= (a_msb_reg == b_msb_reg) & (sum_next[N-1] != a_msb_reg);
        end
    end
`endif

endmodule
